write_path_arbiter: RTL
=======================

# write_path_arbiter

Arbiter and sequencer for the shared downstream AXI write port of the write-ordering top level. It decides, per address transfer, whether the regular master flow (sel=0) or the special-memory replay flow (sel=1) owns the outgoing AW channel. It records each grant in an order queue, then steers the W channel burst by burst in exactly that order, so W bursts never interleave and never overtake their address. Outputs `aw_sel`/`w_sel` drive the existing AW/W data muxes; this block owns only handshake and selection.

## Interface
- `ORDER_DEPTH`, 4: outstanding AW grants whose W burst has not completed (power of 2, 2..16).
- `SPEC_RUN`, 4: max consecutive spec AW grants while reg is waiting (used only with the starvation guard).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `reg_awvalid` in 1 / `reg_awready` out 1: regular-flow AW handshake.
- `spec_awvalid` in 1 / `spec_awready` out 1: special-memory AW handshake.
- `m_awvalid` out 1 / `m_awready` in 1: downstream AW handshake.
- `aw_sel` out 1: AW mux select (0 reg, 1 spec).
- `reg_wvalid`, `reg_wlast` in 1 / `reg_wready` out 1: regular-flow W.
- `spec_wvalid`, `spec_wlast` in 1 / `spec_wready` out 1: special-memory W.
- `m_wvalid` out 1 / `m_wready` in 1: downstream W handshake.
- `w_sel` out 1: W mux select (0 reg, 1 spec).
- `order_full` out 1, `order_empty` out 1: order queue status.
- `order_cnt` out $clog2(ORDER_DEPTH)+1: queue occupancy.

## Operation
- AW FSM states: IDLE, HOLD_REG, HOLD_SPEC.
- IDLE: if `order_full`, no grant and both awready=0. Otherwise spec wins when `spec_awvalid`, else reg wins when `reg_awvalid`. Grant is combinational: `aw_sel`=winner, `m_awvalid`=winner valid, winner awready=`m_awready`, loser awready=0.
- Granted valid with `m_awready`=0 -> go to HOLD_<winner>. Selection stays frozen until `m_awready`=1, then return to IDLE. This satisfies the AXI rule that valid/payload are stable until accepted.
- AW handshake (`m_awvalid`&`m_awready`) pushes the `aw_sel` bit into the order queue.
- W: if queue empty, `m_wvalid`=0 and both wready=0 (W before its AW is stalled, never dropped). Otherwise `w_sel`=head bit, `m_wvalid`=selected wvalid, selected wready=`m_wready`, other wready=0.
- W handshake with selected wlast=1 pops head; the next burst's source applies from the following cycle.
- `aw_sel` in IDLE with no valid holds its last value. `w_sel` with empty queue holds its last value.
- Pointers wrap modulo ORDER_DEPTH. Count = push−pop, 0..ORDER_DEPTH.

## Timing
- Reset: FSM=IDLE, queue empty, `order_cnt`=0, `order_empty`=1, `order_full`=0, `aw_sel`=0, `w_sel`=0, all wready=0, `m_wvalid`=0, run counter=0. AW outputs are combinational from inputs per IDLE rules.
- AW path: zero-cycle combinational valid/ready passthrough.
- AW→W: a burst's W may start the cycle after its AW handshake. No same-cycle bypass.
- `order_full` is registered occupancy. With full plus a pop in the same cycle, AW is still refused that cycle; it is accepted the next.
- Push and pop in the same cycle: count unchanged, both take effect.
- Reset asserted mid-burst: queue and FSM clear immediately. Upstream must be reset together.

## Configuration
- `WPA_STARVE_GUARD_EN` defined: a run counter counts consecutive spec grants taken in IDLE while `reg_awvalid`=1. When it reaches SPEC_RUN, the next IDLE arbitration with `reg_awvalid`=1 grants reg. The counter clears on any reg grant or when `reg_awvalid`=0.
- Undefined: strict spec priority. Counter logic is absent.

## Test plan
- Reg AW, `m_awready`=1, then 4-beat reg W -> `aw_sel`=0, `order_cnt` 0→1→0 after wlast beat, `w_sel`=0, `spec_wready`=0 throughout.
- `reg_awvalid` and `spec_awvalid` both 1 in IDLE -> spec granted first; `m_awready` held 0 for 3 cycles -> HOLD_SPEC, `aw_sel` stays 1, `reg_awready`=0; reg granted after the spec handshake.
- AW order spec, reg, spec, then both sources present W -> W bursts complete in order spec, reg, spec. The non-selected source's wready stays 0.
- ORDER_DEPTH=4: 4 AWs with no W -> `order_full`=1, 5th AW stalled. Final wlast of head -> 5th AW accepted the following cycle.
- W valid with empty queue for 5 cycles -> `m_wvalid`=0, wready=0. AW handshake at cycle 5 -> first W beat accepted at cycle 6.
- `WPA_STARVE_GUARD_EN`, SPEC_RUN=4, both valid continuously -> grant pattern spec×4, reg, spec×4, reg. Without the macro -> spec only.

Source files
------------

// File: rtl/write_path_arbiter.sv
// rtl/write_path_arbiter.sv - AW arbitration and W burst ordering for the shared write port; optional WPA_STARVE_GUARD_EN
module write_path_arbiter #(
    parameter int ORDER_DEPTH = 4,
    parameter int SPEC_RUN    = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           reg_awvalid,
    output logic                           reg_awready,
    input  logic                           spec_awvalid,
    output logic                           spec_awready,
    output logic                           m_awvalid,
    input  logic                           m_awready,
    output logic                           aw_sel,
    input  logic                           reg_wvalid,
    input  logic                           reg_wlast,
    output logic                           reg_wready,
    input  logic                           spec_wvalid,
    input  logic                           spec_wlast,
    output logic                           spec_wready,
    output logic                           m_wvalid,
    input  logic                           m_wready,
    output logic                           w_sel,
    output logic                           order_full,
    output logic                           order_empty,
    output logic [$clog2(ORDER_DEPTH):0]   order_cnt
);
    localparam int PW = $clog2(ORDER_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, HOLD_REG, HOLD_SPEC} aw_state_t;

    aw_state_t              state, state_nxt;
    logic [ORDER_DEPTH-1:0] order_q;
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          cnt;
    logic                   aw_sel_q, w_sel_q;
    logic                   grant_valid, grant_spec;
    logic                   aw_push, w_pop;
    logic                   starve;

`ifdef WPA_STARVE_GUARD_EN
    localparam int RW = $clog2(SPEC_RUN + 1);
    logic [RW-1:0] run_cnt;

    assign starve = reg_awvalid && (run_cnt == RW'(SPEC_RUN));

    // Only grants made in IDLE count; a held grant was already counted when it was made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!reg_awvalid || (state == IDLE && grant_valid && !grant_spec)) begin
            run_cnt <= '0;
        end else if (state == IDLE && grant_valid && grant_spec) begin
            run_cnt <= run_cnt + RW'(1);
        end
    end
`else
    logic [31:0] unused_spec_run;
    assign unused_spec_run = SPEC_RUN;
    assign starve          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            HOLD_REG, HOLD_SPEC: if (m_awready) state_nxt = IDLE;
            default: begin
                if (grant_valid && !m_awready) state_nxt = grant_spec ? HOLD_SPEC : HOLD_REG;
            end
        endcase
    end

    // Idle arbitration keeps the previous selection when nothing is granted.
    always_comb begin
        grant_valid = 1'b0;
        grant_spec  = aw_sel_q;
        unique case (state)
            HOLD_REG: begin
                grant_valid = reg_awvalid;
                grant_spec  = 1'b0;
            end
            HOLD_SPEC: begin
                grant_valid = spec_awvalid;
                grant_spec  = 1'b1;
            end
            default: begin
                if (!order_full) begin
                    if (spec_awvalid && !starve) begin
                        grant_valid = 1'b1;
                        grant_spec  = 1'b1;
                    end else if (reg_awvalid) begin
                        grant_valid = 1'b1;
                        grant_spec  = 1'b0;
                    end
                end
            end
        endcase
    end

    assign aw_sel       = grant_spec;
    assign m_awvalid    = grant_valid;
    assign reg_awready  = grant_valid && !grant_spec && m_awready;
    assign spec_awready = grant_valid && grant_spec && m_awready;
    assign aw_push      = m_awvalid && m_awready;

    assign order_cnt   = cnt;
    assign order_full  = (cnt == CW'(ORDER_DEPTH));
    assign order_empty = (cnt == '0);

    assign w_sel       = order_empty ? w_sel_q : order_q[rd_ptr];
    assign m_wvalid    = !order_empty && (w_sel ? spec_wvalid : reg_wvalid);
    assign reg_wready  = !order_empty && !w_sel && m_wready;
    assign spec_wready = !order_empty && w_sel && m_wready;
    assign w_pop       = m_wvalid && m_wready && (w_sel ? spec_wlast : reg_wlast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            order_q  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            aw_sel_q <= 1'b0;
            w_sel_q  <= 1'b0;
        end else begin
            aw_sel_q <= aw_sel;
            w_sel_q  <= w_sel;
            if (aw_push) begin
                order_q[wr_ptr] <= aw_sel;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (w_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            unique case ({aw_push, w_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end
endmodule
